shift_add_mult_ctrl: RTL
========================

Name: shift_add_mult_ctrl

Overview:
Sequential 16x16 unsigned shift-add multiplier controller. It sequences the team's existing 16-bit claAdder datapath, which is instantiated once and reused on every iteration. The block takes operands with a start/busy/done handshake, runs 16 add-shift iterations and holds the 32-bit product. It is the top of the Multiplier directory, sitting between the requesting logic and the claAdder.

Parameters:
WIDTH, 16, operand width; only 16 is legal because the claAdder is fixed at 16 bits.
CNT_W, 5, width of the iteration counter; must hold the value WIDTH.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
multiplicand  input  16  operand A; latched when start is accepted.
multiplier  input  16  operand B; latched when start is accepted.
busy  output  1  high while in CALC.
done  output  1  one-cycle pulse when the product is valid.
product  output  32  result; held from done until the next accepted start.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, busy=0, done=0, product=0, counter=0, internal registers cleared.
- Registers: mcand[15:0]; acc[15:0]; mq[15:0]; cnt[CNT_W-1:0]. product is defined as {acc,mq}.
- claAdder connections: in1=acc, in2=mcand, cin=0; outputs sum[15:0] and cout. The adder is purely combinational; no adder pipelining is allowed.
- States:
  - IDLE: busy=0. On a clock edge with start=1, latch mcand<=multiplicand, mq<=multiplier, acc<=0, cnt<=0, then go to CALC.
  - CALC: busy=1. Each edge:
    - if mq[0]=1: {acc,mq} <= {cout,sum,mq[15:1]};
    - else: {acc,mq} <= {1'b0,acc,mq[15:1]};
    - cnt<=cnt+1.
    - On the edge where cnt==15 (the 16th iteration), go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0; next edge goes unconditionally to IDLE. start in DONE is ignored.
- Latency:
  - start is accepted at edge E0; iterations occur at edges E1..E16.
  - done is high in the cycle after E16.
  - Start-to-done is 16 cycles; start-to-next-start acceptance is 18 edges minimum.
- Timing is fixed: always 16 iterations regardless of operand values (including zero). There is no early termination.
- product stays stable in IDLE after completion. It changes only once a new start is accepted, when it is re-initialised to {16'h0, multiplier}.
- start asserted while busy or in DONE is ignored; no queueing.
- Operands are sampled only at acceptance; changes during CALC have no effect.
- Reset asserted mid-CALC aborts immediately to IDLE with product=0; no done is issued.
- The carry out of the adder is captured into acc[15] via the shift. No carry is lost; the maximum product 0xFFFE0001 fits in 32 bits.

Decomposition:
- Shared package mult_pkg:
  - WIDTH=16 and ITER=16 constants;
  - 2-bit state encoding: IDLE=2'd0, CALC=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
- Single sub-module: the existing claAdder, instantiated as u_cla. Control FSM and shift register stay in shift_add_mult_ctrl; no further split.

Test Plan:
- Reset during idle, then release -> product=0, busy=0, done=0; a start with A=16'd10, B=16'd20 -> busy for 16 cycles, done pulse, product=32'd200.
- A=16'hFFFF, B=16'hFFFF -> product=32'hFFFE0001; confirms the cout path into acc.
- Back-to-back: A=16'h7FFF, B=16'hFFFF then A=16'hBFFF, B=16'hFFFF, start held high continuously -> products 32'h7FFE8001 then 32'hBFFE4001; second acceptance exactly 18 edges after the first; start during CALC/DONE ignored.
- A=16'd0, B=16'h1234 and A=16'h1234, B=16'd0 -> product=0, done still exactly 16 cycles after start.
- Assert rst at iteration 8 of A=16'd20, B=16'd10 -> immediate IDLE, product=0, no done; a following start with the same operands -> product=32'd200.
- Change multiplicand/multiplier inputs every cycle during CALC for A=16'd10, B=16'd20 -> product still 32'd200; product held unchanged for 10 idle cycles after done.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the sequential shift-add multiplier.
package mult_pkg;
  localparam int WIDTH = 16;
  localparam int ITER  = 16;
  localparam int CNT_W = 5;

  // Encoding 2'd3 is unused and steers back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/claAdder.sv
// 16-bit combinational carry-lookahead adder: 4-bit groups, lookahead across groups.
module claAdder (
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g;
  logic [15:0] p;

  assign g = in1 & in2;
  assign p = in1 ^ in2;

  always_comb begin
    logic       gcarry;
    logic       carry;
    logic [3:0] gg;
    logic [3:0] gp;
    sum    = '0;
    gg     = '0;
    gp     = '0;
    gcarry = cin;
    carry  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      carry = gcarry;
      for (int j = 0; j < 4; j++) begin
        sum[4*k+j] = p[4*k+j] ^ carry;
        carry      = g[4*k+j] | (p[4*k+j] & carry);
      end
      // Group carry comes from group G/P, not from the in-group ripple.
      gcarry = gg[k] | (gp[k] & gcarry);
    end
    cout = gcarry;
  end
endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential 16x16 unsigned shift-add multiplier; reuses one claAdder for all 16 iterations.
// Handshake: start is sampled only in IDLE; busy is high in CALC; done pulses one cycle when product is valid.
module shift_add_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output state_t             dbg_state
);
  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sum;
  logic             cout;

  claAdder u_cla (
    .in1  (acc),
    .in2  (mcand),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: state_d = start ? CALC : IDLE;
      CALC: begin
        busy    = 1'b1;
        state_d = (cnt == CNT_W'(ITER - 1)) ? DONE : CALC;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      acc   <= '0;
      mq    <= '0;
      cnt   <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          mcand <= multiplicand;
          mq    <= multiplier;
          acc   <= '0;
          cnt   <= '0;
        end
        CALC: begin
          // Adder carry lands in acc MSB through the shift, so nothing is dropped.
          if (mq[0]) {acc, mq} <= {cout, sum, mq[WIDTH-1:1]};
          else       {acc, mq} <= {1'b0, acc, mq[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign product   = {acc, mq};
  assign dbg_state = state_q;
endmodule
